// File: rtl/crc_stream_engine.sv
// Table-driven CRC engine: one byte of a BYTES-wide beat is folded per cycle, and in_ready drops for n cycles per n-byte beat.
// The final CRC is held on out_crc/out_valid until the consumer handshakes, and no new beat is accepted in the meantime.
module crc_stream_engine #(
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter int          BYTES   = 4,
  localparam int         NB_W    = $clog2(BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [NB_W-1:0]    in_nbytes,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CRC_W-1:0]   out_crc,
  output logic               busy
);

  localparam logic [CRC_W-1:0] POLY_W  = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_W  = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_W   = XOR_OUT[CRC_W-1:0];
  localparam logic [NB_W-1:0]  NB_FULL = NB_W'(BYTES);

  function automatic logic [CRC_W-1:0] reverse_bits(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int k = 0; k < CRC_W; k++) r[CRC_W-1-k] = v[k];
    return r;
  endfunction

  // Entry i is the CRC_W-bit remainder of byte i after eight shift/XOR steps.
  function automatic logic [256*CRC_W-1:0] gen_table();
    logic [256*CRC_W-1:0] t;
    logic [CRC_W-1:0]     c;
    logic [CRC_W-1:0]     rpoly;
    t     = '0;
    rpoly = reverse_bits(POLY_W);
    for (int i = 0; i < 256; i++) begin
      if (REFLECT) begin
        c = CRC_W'(i);
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
      end else begin
        c = CRC_W'(i) << (CRC_W - 8);
        for (int k = 0; k < 8; k++) c = c[CRC_W-1] ? ((c << 1) ^ POLY_W) : (c << 1);
      end
      t[i*CRC_W +: CRC_W] = c;
    end
    return t;
  endfunction

  localparam logic [256*CRC_W-1:0] CRC_TABLE = gen_table();

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CRC_W-1:0]   crc;
  logic [8*BYTES-1:0] data_q;
  logic               last_q;
  logic [NB_W-1:0]    nbytes_q;
  logic [NB_W-1:0]    byte_cnt;
  logic [NB_W-1:0]    cnt_inc;
  logic [7:0]         tbl_idx;
  logic [CRC_W-1:0]   crc_shift;
  logic [CRC_W-1:0]   crc_next;

  // data_q shifts down one byte per fold, so the current byte is always data_q[7:0].
  always_comb begin
    tbl_idx   = '0;
    crc_shift = '0;
    if (REFLECT) begin
      tbl_idx   = crc[7:0] ^ data_q[7:0];
      crc_shift = crc >> 8;
    end else begin
      tbl_idx   = crc[CRC_W-1 -: 8] ^ data_q[7:0];
      crc_shift = crc << 8;
    end
    crc_next = CRC_TABLE[int'(tbl_idx)*CRC_W +: CRC_W] ^ crc_shift;
  end

  assign cnt_inc = byte_cnt + NB_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= INIT_W;
      data_q    <= '0;
      last_q    <= 1'b0;
      nbytes_q  <= NB_FULL;
      byte_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_crc   <= INIT_W ^ XOR_W;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            last_q   <= in_last;
            nbytes_q <= (!in_last || in_nbytes == '0) ? NB_FULL : in_nbytes;
            byte_cnt <= '0;
            if (in_first) crc <= INIT_W;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PROC;
          end
        end
        PROC: begin
          crc      <= crc_next;
          data_q   <= data_q >> 8;
          byte_cnt <= cnt_inc;
          if (cnt_inc == nbytes_q) begin
            if (last_q) begin
              out_valid <= 1'b1;
              out_crc   <= crc_next ^ XOR_W;
              state     <= DONE;
            end else begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        DONE: begin
          // The next message starts from INIT even if its first beat lacks in_first.
          if (out_ready) begin
            crc       <= INIT_W;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
